mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
// - Shares one sequential multiplier (start/isDone level handshake) among N_REQ requesters.
// - Round-robin grant; latches winner's operands, sequences start/isDone, returns product with one-cycle ack.
// - Sits between client blocks and the multiplier datapath+CU pair; sole driver of the multiplier's start.
// PARAMETERS
// - N_REQ    4   number of requesters (2..8)
// - WIDTH    8   operand width; product is 2*WIDTH
// - TIMEOUT  64  watchdog limit in cycles (used only with MULT_ARB_TIMEOUT_EN)
// PORTS
// - clk        in   1            single clock, all state on posedge
// - rst_n      in   1            asynchronous, active-low reset
// - req        in   N_REQ        level request per client; held until ack
// - a_in       in   N_REQ*WIDTH  packed operand A, client i at [i*WIDTH +: WIDTH]
// - b_in       in   N_REQ*WIDTH  packed operand B, same packing
// - ack        out  N_REQ        one-cycle pulse to the served client, product valid that cycle
// - product    out  2*WIDTH      result of the last completed operation; held until next capture
// - busy       out  1            high from grant until return to IDLE
// - grant_id   out  3            index of current/last granted client
// - mult_a     out  WIDTH        operand A to multiplier (registered at grant)
// - mult_b     out  WIDTH        operand B to multiplier (registered at grant)
// - mult_start out  1            start to multiplier CU
// - mult_done  in   1            isDone from multiplier CU (high in its idle AND end states)
// - mult_p     in   2*WIDTH      multiplier product
// - timeout    out  1            sticky watchdog flag (tied 0 without MULT_ARB_TIMEOUT_EN)
// BEHAVIOUR
// - Reset: state=IDLE, ack=0, product=0, busy=0, grant_id=0, mult_a/b=0, mult_start=0, timeout=0, rr pointer=N_REQ-1.
// - FSM states: IDLE, LAUNCH, RUN, CAPTURE, RELEASE.
// - IDLE: if |req, pick first set bit searching from (ptr+1) mod N_REQ upward with wrap; latch a/b of winner into
//   mult_a/mult_b, grant_id=winner, ptr=winner, busy=1 -> LAUNCH. No req -> stay.
// - LAUNCH: mult_start=1; wait for mult_done==0 (CU left idle) -> RUN. done still 1 -> stay.
// - RUN: mult_start=1; wait for mult_done==1 (CU in end state) -> CAPTURE.
// - CAPTURE: product<=mult_p, ack[grant_id] pulses exactly 1 cycle, mult_start=0 -> RELEASE.
// - RELEASE: mult_start=0 for one full cycle so CU returns to idle; busy=0 -> IDLE. Next grant earliest the cycle after.
// - Latency grant->ack = 1 (LAUNCH min) + multiplier run + 1; back-to-back service gap is 2 cycles (CAPTURE, RELEASE).
// - Operands sampled only at grant; a_in/b_in changes afterwards do not affect the running op.
// - req dropped after grant: operation completes, ack still pulses; no cancel. req dropped before grant: not served.
// - Requests arriving while busy wait; no request is starved: each pending client served within N_REQ grants.
// - Client re-asserting req in its ack cycle competes normally (lowest priority, since ptr = its index).
// - rst_n low mid-operation: immediate return to reset values; mult_start=0 forces CU back through end->idle.
// CONFIGURATION
// - MULT_ARB_TIMEOUT_EN defined: cycle counter runs in LAUNCH/RUN; reaching TIMEOUT sets timeout (sticky until reset),
//   drops mult_start, skips CAPTURE (no ack, product unchanged) and goes to RELEASE; ptr still advances.
// - Not defined: no counter, timeout=0, FSM waits indefinitely in LAUNCH/RUN.
// STRUCTURE
// - Shared package mult_arb_pkg: state enum encoding, default N_REQ/WIDTH/TIMEOUT constants.
// - One sub-module: rr_picker (combinational req + ptr -> winner index, any_valid); FSM, operand regs, watchdog in top.
// TESTING
// - Single req[0], a=7,b=9 -> ack[0] pulses once, product=63, mult_start low at ack+1, busy low after RELEASE.
// - req=4'b1111 held, all ops 3*5 -> acks in order 0,1,2,3,0 each product=15, 2-cycle gap between ops.
// - ptr=1, req=4'b0101 -> grant 2 before 0; then req[2] kept high -> 0 served next (no starvation).
// - req[1] dropped in RUN, a_in changed to 0 -> ack[1] still pulses, product uses latched operands (e.g. 12*12=144).
// - rst_n low during RUN -> all outputs 0 asynchronously; after release, pending req[3] 255*255 -> product=65025.
// - MULT_ARB_TIMEOUT_EN, TIMEOUT=16, mult_done stuck 1 -> timeout=1 after 16 cycles, no ack, FSM back to IDLE.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and default constants for the multiplier-sharing arbiter.
// Provides the FSM state encoding used by mult_share_arbiter.
package mult_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/mult_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit after ptr, with wrap.
// Ports: req (N_REQ), ptr (last winner) -> winner index, any_valid.
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       winner,
  output logic             any_valid
);

  int rank;
  int best;

  // rank = distance past ptr; the lowest-ranked active request wins
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    rank      = 0;
    best      = N_REQ;
    for (int j = 0; j < N_REQ; j++) begin
      rank = (j + N_REQ - int'(ptr) - 1) % N_REQ;
      if (req[j] && rank < best) begin
        best      = rank;
        winner    = 3'(j);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one start/isDone sequential multiplier among N_REQ clients (round robin).
// Ports: req/a_in/b_in in, ack/product/busy/grant_id out, mult_* to CU; MULT_ARB_TIMEOUT_EN adds watchdog.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       ack,
  output logic [2*WIDTH-1:0]     product,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [WIDTH-1:0]       mult_a,
  output logic [WIDTH-1:0]       mult_b,
  output logic                   mult_start,
  input  logic                   mult_done,
  input  logic [2*WIDTH-1:0]     mult_p,
  output logic                   timeout
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mult_share_arbiter: N_REQ must be 2..8, TIMEOUT >= 1");
  end

  state_t           state, state_n;
  logic [2:0]       ptr;
  logic [2:0]       winner;
  logic             any_valid;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             to_hit;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == 3'(i)) begin
        a_sel = a_in[i*WIDTH +: WIDTH];
        b_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          waiting;

  assign waiting = (state == S_LAUNCH && mult_done) ||
                   (state == S_RUN && !mult_done);
  assign to_hit  = waiting && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == S_LAUNCH || state == S_RUN)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      if (to_hit)
        timeout <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (any_valid) state_n = S_LAUNCH;
      S_LAUNCH: begin
        if (!mult_done)  state_n = S_RUN;
        else if (to_hit) state_n = S_RELEASE;
      end
      S_RUN: begin
        if (mult_done)   state_n = S_CAPTURE;
        else if (to_hit) state_n = S_RELEASE;
      end
      S_CAPTURE: state_n = S_RELEASE;
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  assign mult_start = (state == S_LAUNCH) || (state == S_RUN);
  assign busy       = (state != S_IDLE);

  // product and ack are loaded on entry to CAPTURE so both are valid together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= 3'(N_REQ - 1);
      grant_id <= '0;
      mult_a   <= '0;
      mult_b   <= '0;
      product  <= '0;
      ack      <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && any_valid) begin
        grant_id <= winner;
        ptr      <= winner;
        mult_a   <= a_sel;
        mult_b   <= b_sel;
      end
      if (state == S_RUN && mult_done)
        product <= mult_p;
      for (int i = 0; i < N_REQ; i++)
        ack[i] <= (state == S_RUN) && mult_done &&
                  (grant_id == 3'(i));
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier CU.
// Directed table vectors plus hand sequences for RR order, drop, reset, timeout.
module tb_mult_share_arbiter;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int RUN_LEN = 3;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   ack;
  logic [2*W-1:0] product;
  logic           busy;
  logic [2:0]     grant_id;
  logic [W-1:0]   mult_a, mult_b;
  logic           mult_start;
  logic           mult_done;
  logic [2*W-1:0] mult_p;
  logic           timeout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .ack        (ack),
    .product    (product),
    .busy       (busy),
    .grant_id   (grant_id),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_start (mult_start),
    .mult_done  (mult_done),
    .mult_p     (mult_p),
    .timeout    (timeout)
  );

  // CU model: 0 idle, 1 running, 2 end (held until start drops)
  logic [1:0]     cu;
  int             cu_cnt;
  logic [2*W-1:0] cu_p;
  logic           stuck = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cu     <= 2'd0;
      cu_cnt <= 0;
      cu_p   <= '0;
    end else begin
      case (cu)
        2'd0: if (mult_start) begin
          cu     <= 2'd1;
          cu_cnt <= RUN_LEN - 1;
          cu_p   <= {8'b0, mult_a} * {8'b0, mult_b};
        end
        2'd1: if (cu_cnt == 0) cu <= 2'd2;
              else cu_cnt <= cu_cnt - 1;
        default: if (!mult_start) cu <= 2'd0;
      endcase
    end
  end

  assign mult_done = stuck | (cu != 2'd1);
  assign mult_p    = cu_p;

  typedef struct {
    logic [N-1:0] rq;
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [15:0]  exp_p;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic wait_ack(output int id, output logic [15:0] p,
                          output int at);
    id = -1;
    p  = '0;
    at = 0;
    for (int t = 0; t < 200 && id < 0; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) id = i;
        p  = product;
        at = cyc;
        chk("ack_onehot", 32'($onehot(ack)), 32'd1);
      end
    end
    if (id < 0) begin
      tests++;
      fails++;
      $display("FAIL ack_wait: got no ack, required one within 200 cycles");
    end
  endtask

  task automatic wait_busy();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL busy_wait: got busy=0, required busy=1 within 50 cycles");
    end
  endtask

  initial begin
    int          id, at, prev_at;
    logic [15:0] p;
    int          order[5];
    bit          saw_ack;
    int          t0, t_to;

    vecs[0] = '{4'b0001, 0, 8'd16,  8'd16,  16'd256};
    vecs[1] = '{4'b0100, 2, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{4'b0010, 1, 8'd0,   8'd200, 16'd0};
    vecs[3] = '{4'b1000, 3, 8'd1,   8'd128, 16'd128};
    order   = '{0, 1, 2, 3, 0};

    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_product", 32'(product), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_mult_a", 32'(mult_a), 0);
    chk("rst_mult_b", 32'(mult_b), 0);
    chk("rst_mult_start", 32'(mult_start), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single request 7*9 with post-ack handshake timing
    set_ops(0, 8'd7, 8'd9);
    req = 4'b0001;
    wait_ack(id, p, at);
    req = '0;
    chk("single_id", 32'(id), 0);
    chk("single_product", 32'(p), 63);
    @(negedge clk);
    chk("single_ack_len", 32'(ack), 0);
    chk("single_start_off", 32'(mult_start), 0);
    chk("single_busy_release", 32'(busy), 1);
    @(negedge clk);
    chk("single_busy_idle", 32'(busy), 0);

    // table of single-client operations, including 0 and max operands
    for (int v = 0; v < 4; v++) begin
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
      req = vecs[v].rq;
      wait_ack(id, p, at);
      req = '0;
      chk("vec_id", 32'(id), 32'(vecs[v].idx));
      chk("vec_product", 32'(p), 32'(vecs[v].exp_p));
      chk("vec_mult_a", 32'(mult_a), 32'(vecs[v].a));
      repeat (2) @(negedge clk);
    end

    // all four requesting, held: order 0,1,2,3,0 with 8-cycle period
    for (int i = 0; i < N; i++) set_ops(i, 8'd3, 8'd5);
    req = 4'b1111;
    prev_at = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(id, p, at);
      if (k == 4) req = '0;
      chk("rr_id", 32'(id), 32'(order[k]));
      chk("rr_product", 32'(p), 15);
      if (k > 0) chk("rr_period", 32'(at - prev_at), 8);
      prev_at = at;
    end
    repeat (3) @(negedge clk);

    // move ptr to 1, then 0101 grants 2 first; 0 is not starved by 2
    set_ops(1, 8'd2, 8'd3);
    req = 4'b0010;
    wait_ack(id, p, at);
    req = '0;
    chk("ptr1_product", 32'(p), 6);
    repeat (2) @(negedge clk);
    set_ops(0, 8'd5, 8'd5);
    set_ops(2, 8'd4, 8'd4);
    req = 4'b0101;
    wait_ack(id, p, at);
    chk("wrap_first_id", 32'(id), 2);
    chk("wrap_grant_id", 32'(grant_id), 2);
    chk("wrap_first_p", 32'(p), 16);
    wait_ack(id, p, at);
    req = 4'b0100;
    chk("nostarve_id", 32'(id), 0);
    chk("nostarve_p", 32'(p), 25);
    wait_ack(id, p, at);
    req = '0;
    chk("again_id", 32'(id), 2);
    repeat (3) @(negedge clk);

    // req and operands dropped mid-run: latched operands still used
    set_ops(1, 8'd12, 8'd12);
    req = 4'b0010;
    wait_busy();
    repeat (2) @(negedge clk);
    req  = '0;
    a_in = '0;
    b_in = '0;
    chk("drop_mult_a", 32'(mult_a), 12);
    wait_ack(id, p, at);
    chk("drop_id", 32'(id), 1);
    chk("drop_product", 32'(p), 144);
    repeat (3) @(negedge clk);

    // asynchronous reset during run, pending req[3] served afterwards
    set_ops(3, 8'd255, 8'd255);
    req = 4'b1000;
    wait_busy();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ack", 32'(ack), 0);
    chk("arst_product", 32'(product), 0);
    chk("arst_mult_start", 32'(mult_start), 0);
    chk("arst_grant_id", 32'(grant_id), 0);
    chk("arst_mult_a", 32'(mult_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ack(id, p, at);
    req = '0;
    chk("post_rst_id", 32'(id), 3);
    chk("post_rst_product", 32'(p), 65025);
    repeat (3) @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
    // CU never leaves idle: watchdog fires after TO cycles, no ack
    stuck = 1'b1;
    set_ops(0, 8'd9, 8'd9);
    req = 4'b0001;
    wait_busy();
    req     = '0;
    t0      = cyc;
    t_to    = -1;
    saw_ack = 1'b0;
    for (int t = 0; t < 100 && busy; t++) begin
      @(negedge clk);
      if (ack != '0) saw_ack = 1'b1;
      if (timeout && t_to < 0) t_to = cyc;
    end
    chk("to_flag", 32'(timeout), 1);
    chk("to_cycles", 32'(t_to - t0), TO);
    chk("to_no_ack", 32'(saw_ack), 0);
    chk("to_product_kept", 32'(product), 65025);
    chk("to_idle", 32'(busy), 0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    chk("to_sticky", 32'(timeout), 1);
`else
    chk("no_timeout", 32'(timeout), 0);
    saw_ack = 1'b0;
    t0      = 0;
    t_to    = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
